// File: rtl/servo_bank.sv
//==============================================================================
// Module  : servo_bank
// Brief   : Multi-channel hobby-servo PWM generator with double-buffered
//           positions applied at frame boundaries. Optional slew limiting is
//           enabled by defining SERVO_SLEW_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module servo_bank #(
    parameter int CHANNELS  = 4,
    parameter int VAL_W     = 8,
    parameter int CLK_HZ    = 50000000,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int SLEW_STEP = 16,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [CH_W-1:0]     i_wr_ch,
    input  logic [VAL_W-1:0]    i_wr_val,
    input  logic [CHANNELS-1:0] i_ch_en,
    output logic [CHANNELS-1:0] o_servo,
    output logic                o_frame_sync
);

    localparam int C_DIV    = CLK_HZ / 1000000;
    localparam int C_PS_W   = (C_DIV > 2) ? $clog2(C_DIV) : 1;
    localparam int C_FC_W   = $clog2(FRAME_US);
    localparam int C_PROD_W = VAL_W + 11;
    localparam logic [VAL_W-1:0] C_MID = {1'b1, {(VAL_W-1){1'b0}}};

    if (CHANNELS < 1 || CHANNELS > 16 || C_DIV < 2 || MAX_US >= FRAME_US ||
        MIN_US > MAX_US || SLEW_STEP < 1) begin : g_param_chk
        $error("servo_bank: illegal parameter combination");
    end

    logic [C_PS_W-1:0]   r_ps;
    logic [C_FC_W-1:0]   r_fc;
    logic [VAL_W-1:0]    r_pend [CHANNELS];
    logic [VAL_W-1:0]    r_act  [CHANNELS];
    logic [CHANNELS-1:0] r_en_act;
    logic [CHANNELS-1:0] r_servo;
    logic                r_fsync;

    logic                w_tick;
    logic                w_latch;
    logic                w_wr_ok;
    logic [VAL_W-1:0]    w_next  [CHANNELS];
    logic [C_FC_W-1:0]   w_width [CHANNELS];

    assign w_tick  = (r_ps == C_PS_W'(C_DIV - 1));
    assign w_latch = w_tick && (r_fc == C_FC_W'(FRAME_US - 1));
    assign w_wr_ok = i_wr_en && (32'(i_wr_ch) < CHANNELS);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign w_width[i] = C_FC_W'(MIN_US) +
            C_FC_W'((C_PROD_W'(r_act[i]) * C_PROD_W'(MAX_US - MIN_US)) >> VAL_W);
`ifdef SERVO_SLEW_EN
        logic [VAL_W-1:0] w_up;
        logic [VAL_W-1:0] w_dn;
        assign w_up = r_pend[i] - r_act[i];
        assign w_dn = r_act[i] - r_pend[i];
        // Step by at most SLEW_STEP; land exactly on the target when closer.
        assign w_next[i] = (r_pend[i] > r_act[i])
            ? ((32'(w_up) > SLEW_STEP) ? r_act[i] + VAL_W'(SLEW_STEP) : r_pend[i])
            : ((32'(w_dn) > SLEW_STEP) ? r_act[i] - VAL_W'(SLEW_STEP) : r_pend[i]);
`else
        assign w_next[i] = r_pend[i];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps     <= '0;
            r_fc     <= '0;
            r_en_act <= '0;
            r_servo  <= '0;
            r_fsync  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_pend[i] <= C_MID;
                r_act[i]  <= C_MID;
            end
        end else begin
            r_ps    <= w_tick ? '0 : r_ps + C_PS_W'(1);
            r_fsync <= w_latch;
            if (w_latch) begin
                r_fc     <= '0;
                r_en_act <= i_ch_en;
            end else if (w_tick) begin
                r_fc <= r_fc + C_FC_W'(1);
            end
            for (int i = 0; i < CHANNELS; i++) begin
                // Latch reads pending before this edge's write lands.
                if (w_latch) begin
                    r_act[i] <= w_next[i];
                end
                if (w_wr_ok && (32'(i_wr_ch) == i)) begin
                    r_pend[i] <= i_wr_val;
                end
                r_servo[i] <= r_en_act[i] && (r_fc < w_width[i]);
            end
        end
    end

    assign o_servo      = r_servo;
    assign o_frame_sync = r_fsync;

endmodule

`default_nettype wire

// File: tb/tb_servo_bank.sv
//==============================================================================
// Module  : tb_servo_bank
// Brief   : Self-checking bench for servo_bank using a scaled timebase
//           (2 clk per us, 300 us frame, 100..200 us span, 5 channels).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_servo_bank;

    localparam int CH        = 5;
    localparam int VW        = 8;
    localparam int CLK_HZ    = 2000000;
    localparam int FRAME_US  = 300;
    localparam int MIN_US    = 100;
    localparam int MAX_US    = 200;
    localparam int STEP      = 16;
    localparam int FRAME_CLK = FRAME_US * (CLK_HZ / 1000000);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_ch = '0;
    logic [VW-1:0] wr_val = '0;
    logic [CH-1:0] ch_en = '0;
    logic [CH-1:0] servo;
    logic          fsync;

    int checks = 0;
    int errors = 0;

    servo_bank #(
        .CHANNELS (CH),
        .VAL_W    (VW),
        .CLK_HZ   (CLK_HZ),
        .FRAME_US (FRAME_US),
        .MIN_US   (MIN_US),
        .MAX_US   (MAX_US),
        .SLEW_STEP(STEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_ch     (wr_ch),
        .i_wr_val    (wr_val),
        .i_ch_en     (ch_en),
        .o_servo     (servo),
        .o_frame_sync(fsync)
    );

    always #5 clk = ~clk;

    // wr_pos: 0 = no write, 1 = mid-frame write, 2 = write on the latch edge
    typedef struct packed {
        logic [1:0]          wr_pos;
        logic [2:0]          wr_ch;
        logic [VW-1:0]       wr_val;
        logic [CH-1:0]       ch_en;
        logic [CH-1:0][9:0]  exp_w;
    } vec_t;

    function automatic vec_t mk(input int pos, input int wch, input int wval, input int en,
                                input int w0, input int w1, input int w2, input int w3,
                                input int w4);
        vec_t v;
        v.wr_pos   = 2'(pos);
        v.wr_ch    = 3'(wch);
        v.wr_val   = VW'(wval);
        v.ch_en    = CH'(en);
        v.exp_w[0] = 10'(w0);
        v.exp_w[1] = 10'(w1);
        v.exp_w[2] = 10'(w2);
        v.exp_w[3] = 10'(w3);
        v.exp_w[4] = 10'(w4);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Hold reset, check reset outputs, release on a negedge and check frame 1.
    task automatic reset_and_first_frame();
        int n;
        int hi;
        rst_n = 1'b0;
        wr_en = 1'b0;
        ch_en = 5'h1F;
        repeat (3) @(negedge clk);
        check("reset servo", int'(servo), 0);
        check("reset frame_sync", int'(fsync), 0);
        rst_n = 1'b1;
        n  = 0;
        hi = 0;
        do begin
            @(negedge clk);
            n++;
            for (int c = 0; c < CH; c++) hi += int'(servo[c]);
        end while (!fsync && n < 2 * FRAME_CLK);
        check("first frame_sync delay", n, FRAME_CLK);
        check("frame1 servo high cycles", hi, 0);
    endtask

    // One full frame starting just after a frame_sync sample; ends on the next.
    task automatic run_frame(input vec_t v, input string tag);
        int cnt [CH];
        int early;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        early = 0;
        for (int i = 1; i <= FRAME_CLK; i++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) cnt[c] += int'(servo[c]);
            if (i < FRAME_CLK && fsync) early++;
            if (i == FRAME_CLK) check({tag, " frame_sync"}, int'(fsync), 1);
            wr_en = 1'b0;
            if (i == 100) ch_en = v.ch_en;
            if ((v.wr_pos == 2'd1 && i == 100) || (v.wr_pos == 2'd2 && i == FRAME_CLK - 1)) begin
                wr_en  = 1'b1;
                wr_ch  = v.wr_ch;
                wr_val = v.wr_val;
            end
        end
        wr_en = 1'b0;
        check({tag, " stray frame_sync"}, early, 0);
        for (int c = 0; c < CH; c++)
            check($sformatf("%s ch%0d width", tag, c), cnt[c], int'(v.exp_w[c]));
    endtask

    initial begin
        reset_and_first_frame();

`ifndef SERVO_SLEW_EN
        begin
            vec_t tbl [7];
            tbl[0] = mk(1, 1,   0, 5'h1F, 300, 300, 300, 300, 300);
            tbl[1] = mk(2, 2, 255, 5'h1F, 300, 200, 300, 300, 300);
            tbl[2] = mk(1, 4, 255, 5'h1F, 300, 200, 300, 300, 300);
            tbl[3] = mk(1, 5,   0, 5'h17, 300, 200, 398, 300, 398);
            tbl[4] = mk(1, 0,  64, 5'h17, 300, 200, 398,   0, 398);
            tbl[5] = mk(0, 0,   0, 5'h1F, 250, 200, 398,   0, 398);
            tbl[6] = mk(0, 0,   0, 5'h1F, 250, 200, 398, 300, 398);
            for (int k = 0; k < 7; k++)
                run_frame(tbl[k], $sformatf("vec%0d", k));
        end
`else
        begin
            int slew_w [8] = '{312, 324, 336, 350, 362, 374, 386, 398};
            run_frame(mk(1, 0, 255, 5'h1F, 300, 300, 300, 300, 300), "slew0");
            for (int k = 0; k < 8; k++)
                run_frame(mk(0, 0, 0, 5'h1F, slew_w[k], 300, 300, 300, 300),
                          $sformatf("slew%0d", k + 1));
        end
`endif

        // Reset in the middle of a ch0 pulse with a write still pending.
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (i == 20) begin
                wr_en  = 1'b1;
                wr_ch  = 3'd0;
                wr_val = 8'd0;
            end
        end
        check("pre-reset ch0 high", int'(servo[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset servo", int'(servo), 0);
        check("async reset frame_sync", int'(fsync), 0);
        reset_and_first_frame();
        run_frame(mk(0, 0, 0, 5'h1F, 300, 300, 300, 300, 300), "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
